// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, the scan-phase type and helpers that derive
// axis totals and sync-window bounds from the four per-axis segment lengths.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    typedef enum logic [1:0] {
        VISIBLE = 2'd0,
        FRONT   = 2'd1,
        SYNC    = 2'd2,
        BACK    = 2'd3
    } scan_phase_t;

    function automatic int axis_total(input int vis, input int front, input int sync, input int back);
        return vis + front + sync + back;
    endfunction

    function automatic int sync_start(input int vis, input int front);
        return vis + front;
    endfunction

    function automatic int sync_end(input int vis, input int front, input int sync);
        return vis + front + sync;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping counter with phase decode of both the current
// and the next count, so callers can register flags in step with the count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE_LEN = H_VISIBLE_DEF,
    parameter int FRONT_LEN   = H_FRONT_DEF,
    parameter int SYNC_LEN    = H_SYNC_DEF,
    parameter int BACK_LEN    = H_BACK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output scan_phase_t      phase,
    output logic             sync_n_nxt,
    output logic             active_nxt,
    output logic             wrap
);

    localparam int TOTAL = axis_total(VISIBLE_LEN, FRONT_LEN, SYNC_LEN, BACK_LEN);
    localparam logic [CNT_W-1:0] LAST        = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(VISIBLE_LEN);
    localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(sync_start(VISIBLE_LEN, FRONT_LEN));
    localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(sync_end(VISIBLE_LEN, FRONT_LEN, SYNC_LEN));

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;
    scan_phase_t      phase_nxt;

    function automatic scan_phase_t decode_phase(input logic [CNT_W-1:0] c);
        if (c < FRONT_START) return VISIBLE;
        if (c < SYNC_START)  return FRONT;
        if (c < BACK_START)  return SYNC;
        return BACK;
    endfunction

    always_comb begin
        wrap    = inc && (count_q == LAST);
        count_d = count_q;
        if (wrap) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
        phase_nxt = decode_phase(count_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign phase      = decode_phase(count_q);
    assign sync_n_nxt = (phase_nxt != SYNC);
    assign active_nxt = (phase_nxt == VISIBLE);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: H/V counters, registered active-low syncs and blank, frame
// strobe and frame counter. Define VGA_SYNC_DELAY_EN to delay hs/vs one enabled pixel.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        pixel_en,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        frame_end,
    output logic [7:0]  frame_count
);

    scan_phase_t h_phase;
    scan_phase_t v_phase;
    logic        h_sync_n_nxt;
    logic        v_sync_n_nxt;
    logic        h_active_nxt;
    logic        v_active_nxt;
    logic        h_wrap;
    logic        v_wrap;

    logic        hs_d, hs_q;
    logic        vs_d, vs_q;
    logic        blank_d, blank_q;
    logic [7:0]  frame_count_d, frame_count_q;

    vga_axis_counter #(
        .VISIBLE_LEN (H_VISIBLE),
        .FRONT_LEN   (H_FRONT),
        .SYNC_LEN    (H_SYNC),
        .BACK_LEN    (H_BACK)
    ) u_h_axis (
        .clk        (vga_clk),
        .rst_n      (reset_n),
        .inc        (pixel_en),
        .count      (DrawX),
        .phase      (h_phase),
        .sync_n_nxt (h_sync_n_nxt),
        .active_nxt (h_active_nxt),
        .wrap       (h_wrap)
    );

    vga_axis_counter #(
        .VISIBLE_LEN (V_VISIBLE),
        .FRONT_LEN   (V_FRONT),
        .SYNC_LEN    (V_SYNC),
        .BACK_LEN    (V_BACK)
    ) u_v_axis (
        .clk        (vga_clk),
        .rst_n      (reset_n),
        .inc        (h_wrap),
        .count      (DrawY),
        .phase      (v_phase),
        .sync_n_nxt (v_sync_n_nxt),
        .active_nxt (v_active_nxt),
        .wrap       (v_wrap)
    );

    // The V wrap fires only on the last pixel of the last line of an enabled cycle.
    assign frame_end = v_wrap;

    // Flags follow the next-state decode when the axis advances, else the current one.
    always_comb begin
        hs_d          = pixel_en ? h_sync_n_nxt : (h_phase != SYNC);
        vs_d          = h_wrap ? v_sync_n_nxt : (v_phase != SYNC);
        blank_d       = pixel_en ? (h_active_nxt && v_active_nxt)
                                 : ((h_phase == VISIBLE) && (v_phase == VISIBLE));
        frame_count_d = frame_count_q + {7'd0, frame_end};
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b1;
            frame_count_q <= 8'd0;
        end else begin
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign blank       = blank_q;
    assign frame_count = frame_count_q;

`ifdef VGA_SYNC_DELAY_EN
    logic hs_dly_d, hs_dly_q;
    logic vs_dly_d, vs_dly_q;

    // Extra enabled stage lines syncs up with the renderer's registered RGB.
    always_comb begin
        hs_dly_d = pixel_en ? hs_q : hs_dly_q;
        vs_dly_d = pixel_en ? vs_q : vs_dly_q;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_dly_q <= 1'b1;
            vs_dly_q <= 1'b1;
        end else begin
            hs_dly_q <= hs_dly_d;
            vs_dly_q <= vs_dly_d;
        end
    end

    assign hs = hs_dly_q;
    assign vs = vs_dly_q;
`else
    assign hs = hs_q;
    assign vs = vs_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a reduced raster (55x39) so whole
// frames, the half-rate enable pattern and a mid-frame reset stay short.
module tb_vga_timing_gen;

    localparam int HV = 40, HF = 4, HS = 6, HB = 5, HT = 55;
    localparam int VV = 30, VF = 3, VS = 2, VB = 4, VT = 39;

`ifdef VGA_SYNC_DELAY_EN
    localparam logic EXP_HS44 = 1'b1, EXP_HS45 = 1'b0, EXP_HS50 = 1'b0, EXP_HS51 = 1'b1;
    localparam int   EXP_VS_YMAX = 35;
`else
    localparam logic EXP_HS44 = 1'b0, EXP_HS45 = 1'b0, EXP_HS50 = 1'b1, EXP_HS51 = 1'b1;
    localparam int   EXP_VS_YMAX = 34;
`endif

    logic       vga_clk = 1'b0;
    logic       reset_n;
    logic       pixel_en;
    logic       hs, vs, blank, frame_end;
    logic [9:0] DrawX, DrawY;
    logic [7:0] frame_count;

    int checks = 0;
    int errors = 0;

    int mx = 0, my = 0, edges = 0;
    int xy_err = 0, blank_err = 0, hs_lo_cnt = 0, vs_lo_cnt = 0;
    int vs_ymin = 1023, vs_ymax = 0;
    int fe_cnt = 0, fe_x = 0, fe_y = 0, fe_edge = 0, fe_fc = 0;
    logic hs_line    [0:HT-1];
    logic blank_line [0:HT-1];

    int          t_edges, changes, fe_dis, guard;
    logic [30:0] snap_prev, snap_now;

    vga_timing_gen #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .pixel_en    (pixel_en),
        .hs          (hs),
        .vs          (vs),
        .blank       (blank),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .frame_end   (frame_end),
        .frame_count (frame_count)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    // Advance the bench's own raster position and fold the DUT outputs into tallies.
    task automatic sample_frame();
        edges++;
        if (mx == HT - 1) begin
            mx = 0;
            my = (my == VT - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
        if (DrawX !== mx[9:0] || DrawY !== my[9:0]) xy_err++;
        if (blank !== ((mx < HV) && (my < VV))) blank_err++;
        if (DrawY == 10'd0 && DrawX < 10'(HT)) begin
            hs_line[DrawX]    = hs;
            blank_line[DrawX] = blank;
            if (!hs) hs_lo_cnt++;
        end
        if (!vs) begin
            vs_lo_cnt++;
            if (int'(DrawY) < vs_ymin) vs_ymin = int'(DrawY);
            if (int'(DrawY) > vs_ymax) vs_ymax = int'(DrawY);
        end
        if (frame_end) begin
            fe_cnt++;
            fe_x    = int'(DrawX);
            fe_y    = int'(DrawY);
            fe_edge = edges;
            fe_fc   = int'(frame_count);
        end
    endtask

    function automatic logic [30:0] snapshot();
        return {DrawX, DrawY, hs, vs, blank, frame_count};
    endfunction

    initial begin
        // Reset held with pixel_en high: nothing may move.
        reset_n  = 1'b0;
        pixel_en = 1'b1;
        repeat (3) @(posedge vga_clk);
        #1;
        check("rst_drawx", DrawX, 0);
        check("rst_drawy", DrawY, 0);
        check("rst_hs", hs, 1);
        check("rst_vs", vs, 1);
        check("rst_blank", blank, 1);
        check("rst_frame_end", frame_end, 0);
        check("rst_frame_count", frame_count, 0);

        @(negedge vga_clk);
        reset_n = 1'b1;
        step();
        sample_frame();
        check("first_drawx", DrawX, 1);
        check("first_drawy", DrawY, 0);

        // One full frame with pixel_en held high.
        do begin
            step();
            sample_frame();
        end while (!frame_end && edges < 3000);

        check("frame_xy_track", xy_err, 0);
        check("frame_blank_map", blank_err, 0);
        check("hs_x43", hs_line[43], 1);
        check("hs_x44", hs_line[44], EXP_HS44);
        check("hs_x45", hs_line[45], EXP_HS45);
        check("hs_x50", hs_line[50], EXP_HS50);
        check("hs_x51", hs_line[51], EXP_HS51);
        check("hs_low_count", hs_lo_cnt, HS);
        check("blank_x39", blank_line[39], 1);
        check("blank_x40", blank_line[40], 0);
        check("vs_low_count", vs_lo_cnt, VS * HT);
        check("vs_first_line", vs_ymin, 33);
        check("vs_last_line", vs_ymax, EXP_VS_YMAX);
        check("frame_end_pulses", fe_cnt, 1);
        check("frame_end_edge", fe_edge, HT * VT - 1);
        check("frame_end_x", fe_x, HT - 1);
        check("frame_end_y", fe_y, VT - 1);
        check("frame_end_count_before", fe_fc, 0);

        step();
        check("wrap_drawx", DrawX, 0);
        check("wrap_drawy", DrawY, 0);
        check("wrap_frame_count", frame_count, 1);
        check("wrap_frame_end", frame_end, 0);

        // Half-rate enable: disabled edges must freeze everything.
        pixel_en  = 1'b0;
        t_edges   = 0;
        changes   = 0;
        fe_dis    = 0;
        snap_prev = snapshot();
        while (frame_count == 8'd1 && t_edges < 6000) begin
            step();
            t_edges++;
            snap_now = snapshot();
            if (!pixel_en && snap_now != snap_prev) changes++;
            snap_prev = snap_now;
            pixel_en  = ~pixel_en;
            #1;
            if (!pixel_en && frame_end) fe_dis++;
        end
        check("toggle_frame_edges", t_edges, 2 * HT * VT);
        check("toggle_frame_count", frame_count, 2);
        check("toggle_drawx", DrawX, 0);
        check("toggle_drawy", DrawY, 0);
        check("toggle_frozen", changes, 0);
        check("toggle_fe_disabled", fe_dis, 0);

        // Asynchronous reset mid-frame while in hsync and vsync.
        pixel_en = 1'b1;
        guard    = 0;
        while (!(DrawX == 10'd45 && DrawY == 10'd33) && guard < 3000) begin
            step();
            guard++;
        end
        check("reach_45_33", (DrawX == 10'd45 && DrawY == 10'd33), 1);
        check("pre_rst_hs", hs, 0);
        check("pre_rst_vs", vs, 0);
        check("pre_rst_blank", blank, 0);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_drawx", DrawX, 0);
        check("async_drawy", DrawY, 0);
        check("async_hs", hs, 1);
        check("async_vs", vs, 1);
        check("async_blank", blank, 1);
        check("async_frame_count", frame_count, 0);
        check("async_frame_end", frame_end, 0);

        repeat (2) @(posedge vga_clk);
        @(negedge vga_clk);
        reset_n = 1'b1;
        step();
        check("rerun_drawx", DrawX, 1);
        check("rerun_drawy", DrawY, 0);
        check("rerun_frame_count", frame_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates the VGA raster scan: horizontal/vertical counters, active-low sync pulses, the active-video flag `blank` and the `DrawX`/`DrawY` pixel coordinates.
- These signals drive the sprite/pixel renderers, which read ROM on the falling edge and register RGB on the rising edge.
- Also emits an end-of-frame strobe and a frame counter, used by game logic to update sprite positions once per frame.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports (one clock, `vga_clk`; reset `reset_n` is asynchronous, active-low):
- vga_clk  in  1  pixel clock, all logic on posedge
- reset_n  in  1  asynchronous active-low reset
- pixel_en  in  1  advance scan by one pixel when high
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- blank  out  1  high = active video (renderer drives RGB only when high)
- DrawX  out  10  current column, 0..H_TOTAL-1
- DrawY  out  10  current line, 0..V_TOTAL-1
- frame_end  out  1  one-cycle strobe on last pixel of frame
- frame_count  out  8  completed frames, wraps 255→0

## Operation
- H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525). All totals must be ≤ 1024.
- Horizontal counter:
  - Increments when pixel_en=1.
  - At H_TOTAL-1 it wraps to 0, and the vertical counter increments.
  - The vertical counter wraps from V_TOTAL-1 to 0.
- DrawX and DrawY are the counter registers themselves.
- Horizontal phase sequence: VISIBLE [0,H_VISIBLE) → FRONT → SYNC [656,752) → BACK → VISIBLE.
- Vertical phase sequence, using the same pattern: SYNC is lines [490,492).
- blank=1 iff DrawX<H_VISIBLE and DrawY<V_VISIBLE.
- hs=0 iff the horizontal phase is SYNC.
- vs=0 iff the vertical phase is SYNC (for the whole line, independent of DrawX).
- frame_end = pixel_en & (DrawX==H_TOTAL-1) & (DrawY==V_TOTAL-1). This is combinational from registers.
- frame_count increments on the edge where frame_end=1.
- pixel_en=0:
  - Counters, hs, vs, blank and frame_count all hold.
  - frame_end is 0.
- Reset values: DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_count=0, frame_end=0.
- Reset asserted mid-frame returns to (0,0) immediately. No frame_end is generated for the truncated frame.

## Timing
- hs, vs and blank are registered.
- Each is decoded from the next-state counter values, so it changes on the same edge as DrawX/DrawY. There is zero skew between coordinates and flags.
- First posedge with pixel_en=1 after reset release: DrawX=1, DrawY=0.
- Line period: H_TOTAL enabled cycles. hs is low for exactly H_SYNC enabled cycles per line.
- Frame period: H_TOTAL×V_TOTAL enabled cycles (420000). vs is low for V_SYNC×H_TOTAL enabled cycles.
- Simultaneous H wrap and V wrap (end of frame): both counters return to 0 on the same edge, and frame_count increments on that edge.

## Configuration
- Macro VGA_SYNC_DELAY_EN.
- Defined: hs and vs pass through one extra register, stage-enabled by pixel_en, and lag DrawX/DrawY by one enabled cycle. This matches the renderer's one-cycle registered RGB. The delay registers reset to 1. blank, DrawX, DrawY, frame_end and frame_count are unaffected.
- Undefined: hs and vs align with DrawX/DrawY as described in Timing.

## Structure
- Package vga_timing_pkg holds:
  - default timing constants
  - localparam functions for H_TOTAL/V_TOTAL and the sync start/end indices
  - enum typedef scan_phase_t {VISIBLE, FRONT, SYNC, BACK}
- Sub-module vga_axis_counter:
  - generic wrap counter with phase decode
  - parameterized by visible/front/sync/back
  - inputs: clock, reset, increment
  - outputs: count, phase, next-phase sync/active flags, wrap strobe
- The top instantiates it twice:
  - H instance, incremented by pixel_en
  - V instance, incremented by the H wrap strobe
- The top adds frame_count, frame_end and the optional sync delay.

## Test plan
- Reset with pixel_en=1 held, release, then run 800 cycles → DrawX goes 0..799 then 0; DrawY increments 0→1 on the wrap edge; blank is 1 through DrawX=639 and 0 for 640..799.
- Run one line → hs is 0 exactly while DrawX∈[656,751] (96 cycles); hs=1 at DrawX=655 and at 752.
- Run one full frame → vs is 0 only on lines 490 and 491; frame_end pulses once at (799,524); frame_count goes 0→1; the next cycle is (0,0).
- Toggle pixel_en in a 1-on/1-off pattern → the frame takes 840000 cycles; no output changes on disabled cycles; frame_end is never high with pixel_en=0.
- Assert reset_n=0 asynchronously at (300,200) → all outputs reach reset values before the next posedge; frame_count=0; no frame_end.
- With VGA_SYNC_DELAY_EN defined → hs falls one enabled cycle after DrawX reaches 656 and rises one cycle after DrawX reaches 752; blank timing is unchanged.
